axi_txn_logger: RTL and testbench

AXI_TXN_LOGGER -- requirements
Module: axi_txn_logger

---
 rtl/axi_logger_pkg.sv | 38 +++
 rtl/logger_sdp_ram.sv | 40 ++++
 rtl/axi_txn_logger.sv | 213 +++++++++++++++++++++
 tb/tb_axi_txn_logger.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_logger_pkg.sv
// Shared types and entry-layout helpers for the AXI transaction logger.
// Entries are packed LSB first: timestamp, address, ID, length, channel index.
package axi_logger_pkg;

    typedef enum logic [1:0] {
        ST_READY    = 2'd0,
        ST_FULL     = 2'd1,
        ST_CLEARING = 2'd2
    } log_state_e;

    localparam int DROP_CNT_BITW = 16;

    function automatic int ch_bitw(input int num_ch);
        return (num_ch > 2) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int entry_bitw(input int ts_w, input int addr_w, input int id_w,
                                      input int len_w, input int num_ch);
        return ts_w + addr_w + id_w + len_w + ch_bitw(num_ch);
    endfunction

    function automatic int off_addr(input int ts_w);
        return ts_w;
    endfunction

    function automatic int off_id(input int ts_w, input int addr_w);
        return ts_w + addr_w;
    endfunction

    function automatic int off_len(input int ts_w, input int addr_w, input int id_w);
        return ts_w + addr_w + id_w;
    endfunction

    function automatic int off_ch(input int ts_w, input int addr_w, input int id_w, input int len_w);
        return ts_w + addr_w + id_w + len_w;
    endfunction

endpackage

// File: rtl/logger_sdp_ram.sv
// Simple dual-port log storage: one write port, one registered read port.
// A read colliding with a write to the same address returns the old word.
module logger_sdp_ram
    import axi_logger_pkg::*;
#(
    parameter int DATA_W = 81,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Only the output register is reset; the array is zeroed by the clearing pass.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_txn_logger.sv
// Captures AXI address handshakes from several channels into a timestamped log,
// arbitrating one pending entry per cycle into an on-chip RAM.
module axi_txn_logger
    import axi_logger_pkg::*;
#(
    parameter int AXI_ADDR_BITW  = 32,
    parameter int AXI_ID_BITW    = 8,
    parameter int AXI_LEN_BITW   = 8,
    parameter int TIMESTAMP_BITW = 32,
    parameter int NUM_CH         = 2,
    parameter int DEPTH          = 4096,
    parameter int AF_MARGIN      = 1024,
    parameter int WRAP_MODE      = 0
) (
    input  logic                                Clk_CI,
    input  logic                                Rst_RBI,
    input  logic [NUM_CH-1:0]                   AxiValid_SI,
    input  logic [NUM_CH-1:0]                   AxiReady_SI,
    input  logic [NUM_CH*AXI_ID_BITW-1:0]       AxiId_DI,
    input  logic [NUM_CH*AXI_ADDR_BITW-1:0]     AxiAddr_DI,
    input  logic [NUM_CH*AXI_LEN_BITW-1:0]      AxiLen_DI,
    input  logic                                Enable_SI,
    input  logic                                Clear_SI,
    output logic                                Full_SO,
    output logic                                AlmostFull_SO,
    output logic                                Wrapped_SO,
    output logic                                Busy_SO,
    output logic [$clog2(DEPTH)-1:0]            WrPtr_DO,
    output logic [$clog2(DEPTH):0]              NumEntries_DO,
    output logic [DROP_CNT_BITW-1:0]            DropCnt_DO,
    input  logic                                RdEn_SI,
    input  logic [$clog2(DEPTH)-1:0]            RdAddr_DI,
    output logic [entry_bitw(TIMESTAMP_BITW, AXI_ADDR_BITW, AXI_ID_BITW,
                             AXI_LEN_BITW, NUM_CH)-1:0] RdData_DO
);

    localparam int CH_BITW    = ch_bitw(NUM_CH);
    localparam int PTR_W      = $clog2(DEPTH);
    localparam int ENTRY_BITW = entry_bitw(TIMESTAMP_BITW, AXI_ADDR_BITW, AXI_ID_BITW,
                                           AXI_LEN_BITW, NUM_CH);
    localparam int OFF_ADDR   = off_addr(TIMESTAMP_BITW);
    localparam int OFF_ID     = off_id(TIMESTAMP_BITW, AXI_ADDR_BITW);
    localparam int OFF_LEN    = off_len(TIMESTAMP_BITW, AXI_ADDR_BITW, AXI_ID_BITW);
    localparam int OFF_CH     = off_ch(TIMESTAMP_BITW, AXI_ADDR_BITW, AXI_ID_BITW, AXI_LEN_BITW);

    localparam logic [PTR_W-1:0]         PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [PTR_W:0]           NUM_MAX   = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]           NUM_LAST  = (PTR_W + 1)'(DEPTH - 1);
    localparam logic [PTR_W:0]           AF_LEVEL  = (PTR_W + 1)'(DEPTH - AF_MARGIN);
    localparam logic [CH_BITW-1:0]       LAST_INIT = CH_BITW'(NUM_CH - 1);
    localparam logic [DROP_CNT_BITW-1:0] DROP_SAT  = '1;

    log_state_e                  state_q;
    logic [PTR_W-1:0]            wr_ptr_q;
    logic [PTR_W-1:0]            clr_cnt_q;
    logic [PTR_W:0]              num_q;
    logic [DROP_CNT_BITW-1:0]    drop_q;
    logic                        wrapped_q;
    logic [NUM_CH-1:0]           pending_q;
    logic [ENTRY_BITW-1:0]       pend_data_q [NUM_CH];
    logic [TIMESTAMP_BITW-1:0]   ts_q;
    logic [CH_BITW-1:0]          last_grant_q;

    logic [NUM_CH-1:0][ENTRY_BITW-1:0] cap_entry;
    logic [NUM_CH-1:0]           handshake;
    logic [NUM_CH-1:0]           capture;
    logic [NUM_CH-1:0]           grant_oh;
    logic [NUM_CH-1:0]           blocked;
    logic [NUM_CH-1:0]           accept;
    logic [NUM_CH-1:0]           drop_vec;
    logic                        grant_vld;
    logic [CH_BITW-1:0]          grant_idx;
    logic                        full_drop;
    logic                        drop_any;
    logic                        ram_we;
    logic [PTR_W-1:0]            ram_waddr;
    logic [ENTRY_BITW-1:0]       ram_wdata;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_entry
            assign cap_entry[gi][0 +: TIMESTAMP_BITW]       = ts_q;
            assign cap_entry[gi][OFF_ADDR +: AXI_ADDR_BITW] = AxiAddr_DI[gi*AXI_ADDR_BITW +: AXI_ADDR_BITW];
            assign cap_entry[gi][OFF_ID +: AXI_ID_BITW]     = AxiId_DI[gi*AXI_ID_BITW +: AXI_ID_BITW];
            assign cap_entry[gi][OFF_LEN +: AXI_LEN_BITW]   = AxiLen_DI[gi*AXI_LEN_BITW +: AXI_LEN_BITW];
            assign cap_entry[gi][OFF_CH +: CH_BITW]         = CH_BITW'(gi);
        end
    endgenerate

    assign handshake = AxiValid_SI & AxiReady_SI;
    assign capture   = handshake & {NUM_CH{Enable_SI & ~Clear_SI & (state_q == ST_READY)}};

    // Round-robin: search starts at the channel after the last one granted.
    always_comb begin
        logic [CH_BITW-1:0] c_idx;
        c_idx     = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        if (state_q == ST_READY) begin
            for (int k = 1; k <= NUM_CH; k++) begin
                c_idx = CH_BITW'((int'(last_grant_q) + k) % NUM_CH);
                if (!grant_vld && pending_q[c_idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = c_idx;
                    grant_oh  = NUM_CH'(1) << c_idx;
                end
            end
        end
    end

    assign blocked   = pending_q & ~grant_oh;
    assign accept    = capture & ~blocked;
    assign drop_vec  = capture & blocked;
    assign full_drop = (state_q == ST_FULL) &&
                       ((|(handshake & {NUM_CH{Enable_SI}})) || (|pending_q));
    assign drop_any  = (|drop_vec) || full_drop;

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = wr_ptr_q;
        ram_wdata = pend_data_q[grant_idx];
        if (Rst_RBI && !Clear_SI) begin
            if (state_q == ST_CLEARING) begin
                ram_we    = 1'b1;
                ram_waddr = clr_cnt_q;
                ram_wdata = '0;
            end else if (grant_vld) begin
                ram_we = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk_CI) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (accept[i]) begin
                pend_data_q[i] <= cap_entry[i];
            end
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI || Clear_SI) begin
            state_q      <= ST_CLEARING;
            wr_ptr_q     <= '0;
            clr_cnt_q    <= '0;
            num_q        <= '0;
            drop_q       <= '0;
            wrapped_q    <= 1'b0;
            pending_q    <= '0;
            ts_q         <= '0;
            last_grant_q <= LAST_INIT;
        end else begin
            ts_q <= (state_q == ST_CLEARING) ? '0 : ts_q + TIMESTAMP_BITW'(1);
            if (drop_any && drop_q != DROP_SAT) begin
                drop_q <= drop_q + DROP_CNT_BITW'(1);
            end
            case (state_q)
                ST_CLEARING: begin
                    clr_cnt_q <= clr_cnt_q + PTR_W'(1);
                    if (clr_cnt_q == PTR_LAST) begin
                        state_q <= ST_READY;
                    end
                end
                ST_READY: begin
                    pending_q <= blocked | accept;
                    if (grant_vld) begin
                        last_grant_q <= grant_idx;
                        wr_ptr_q     <= wr_ptr_q + PTR_W'(1);
                        if (num_q != NUM_MAX) begin
                            num_q <= num_q + (PTR_W + 1)'(1);
                        end
                        if (WRAP_MODE != 0 && wr_ptr_q == PTR_LAST) begin
                            wrapped_q <= 1'b1;
                        end
                        if (WRAP_MODE == 0 && num_q == NUM_LAST) begin
                            state_q <= ST_FULL;
                        end
                    end
                end
                ST_FULL: begin
                    pending_q <= '0;
                end
                default: begin
                    state_q <= ST_CLEARING;
                end
            endcase
        end
    end

    logger_sdp_ram #(
        .DATA_W (ENTRY_BITW),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk_i   (Clk_CI),
        .rst_ni  (Rst_RBI),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .re_i    (RdEn_SI),
        .raddr_i (RdAddr_DI),
        .rdata_o (RdData_DO)
    );

    assign Full_SO       = (state_q == ST_FULL);
    assign AlmostFull_SO = (WRAP_MODE == 0) && (num_q >= AF_LEVEL);
    assign Wrapped_SO    = wrapped_q;
    assign Busy_SO       = (state_q == ST_CLEARING);
    assign WrPtr_DO      = wr_ptr_q;
    assign NumEntries_DO = num_q;
    assign DropCnt_DO    = drop_q;

endmodule

// File: tb/tb_axi_txn_logger.sv
// Directed bench: one stop-when-full and one ring-buffer logger share stimulus.
module tb_axi_txn_logger;

    localparam int EW = 81;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    valid, ready;
    logic [15:0]   id;
    logic [63:0]   addr;
    logic [15:0]   len;
    logic          en, clr, rd_en;
    logic [3:0]    rd_addr;

    logic          full0, af0, wrapped0, busy0;
    logic [3:0]    ptr0;
    logic [4:0]    num0;
    logic [15:0]   drop0;
    logic [EW-1:0] rdata0;
    logic          full1, af1, wrapped1, busy1;
    logic [3:0]    ptr1;
    logic [4:0]    num1;
    logic [15:0]   drop1;
    logic [EW-1:0] rdata1;

    int            checks = 0;
    int            errors = 0;
    logic [31:0]   ts_exp;
    logic [31:0]   t0;
    logic [EW-1:0] d0, d1;

    always #5 clk = ~clk;

    axi_txn_logger #(.NUM_CH(2), .DEPTH(16), .AF_MARGIN(4), .WRAP_MODE(0)) u_dut0 (
        .Clk_CI(clk), .Rst_RBI(rst_n), .AxiValid_SI(valid), .AxiReady_SI(ready),
        .AxiId_DI(id), .AxiAddr_DI(addr), .AxiLen_DI(len), .Enable_SI(en), .Clear_SI(clr),
        .Full_SO(full0), .AlmostFull_SO(af0), .Wrapped_SO(wrapped0), .Busy_SO(busy0),
        .WrPtr_DO(ptr0), .NumEntries_DO(num0), .DropCnt_DO(drop0),
        .RdEn_SI(rd_en), .RdAddr_DI(rd_addr), .RdData_DO(rdata0));

    axi_txn_logger #(.NUM_CH(2), .DEPTH(16), .AF_MARGIN(4), .WRAP_MODE(1)) u_dut1 (
        .Clk_CI(clk), .Rst_RBI(rst_n), .AxiValid_SI(valid), .AxiReady_SI(ready),
        .AxiId_DI(id), .AxiAddr_DI(addr), .AxiLen_DI(len), .Enable_SI(en), .Clear_SI(clr),
        .Full_SO(full1), .AlmostFull_SO(af1), .Wrapped_SO(wrapped1), .Busy_SO(busy1),
        .WrPtr_DO(ptr1), .NumEntries_DO(num1), .DropCnt_DO(drop1),
        .RdEn_SI(rd_en), .RdAddr_DI(rd_addr), .RdData_DO(rdata1));

    function automatic logic [127:0] ent(input logic ch, input logic [7:0] l, input logic [7:0] i,
                                         input logic [31:0] a, input logic [31:0] t);
        return {47'd0, ch, l, i, a, t};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Timestamp reference: held at 0 while clearing or during a clear request.
    task automatic tick();
        logic hold;
        hold = clr | busy0;
        @(posedge clk);
        #1;
        ts_exp = hold ? 32'd0 : ts_exp + 32'd1;
    endtask

    task automatic rd(input logic [3:0] a, output logic [EW-1:0] r0, output logic [EW-1:0] r1);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        rd_en = 1'b0;
        r0    = rdata0;
        r1    = rdata1;
    endtask

    task automatic wait_clear(input string tag);
        int n;
        n = 0;
        while (busy0 === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        chk(tag, 128'(n), 128'd16);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; valid = '0; ready = 2'b11; id = '0; addr = '0; len = '0;
        en = 1'b1; clr = 1'b0; rd_en = 1'b0; rd_addr = '0; ts_exp = '0;
        tick();
        tick();
        ts_exp = '0;
        chk("rst_busy", 128'(busy0), 128'd1);
        chk("rst_wrptr", 128'(ptr0), 128'd0);
        chk("rst_num", 128'(num0), 128'd0);
        chk("rst_drop", 128'(drop0), 128'd0);
        chk("rst_rdata", 128'(rdata0), 128'd0);
        chk("rst_wrapped", 128'(wrapped1), 128'd0);
        chk("rst_full", 128'(full0), 128'd0);

        rst_n = 1'b1;
        wait_clear("rst_busy_cycles");
        chk("ready_after_clear", 128'(busy0), 128'd0);
        for (int a = 0; a < 16; a++) begin
            rd(4'(a), d0, d1);
            chk("init_mem_zero", 128'(d0), 128'd0);
        end

        // Both channels in one cycle: ch0 lands first, ch1 next.
        valid = 2'b11;
        addr  = {32'h0000_0200, 32'h0000_0100};
        id    = {8'h22, 8'h11};
        len   = {8'h04, 8'h03};
        t0    = ts_exp;
        tick();
        valid = 2'b00;
        chk("lat_num_t", 128'(num0), 128'd0);
        rd_en = 1'b1; rd_addr = 4'd0;
        tick();
        rd_en = 1'b0;
        chk("collide_old_data", 128'(rdata0), 128'd0);
        chk("lat_num_t1", 128'(num0), 128'd1);
        rd_en = 1'b1; rd_addr = 4'd0;
        tick();
        rd_en = 1'b0;
        chk("lat_read_t2", 128'(rdata0), ent(1'b0, 8'h03, 8'h11, 32'h100, t0));
        chk("dual_num", 128'(num0), 128'd2);
        chk("dual_wrptr", 128'(ptr0), 128'd2);
        chk("dual_drop", 128'(drop0), 128'd0);
        rd(4'd1, d0, d1);
        chk("dual_ch1_entry", 128'(d0), ent(1'b1, 8'h04, 8'h22, 32'h200, t0));
        tick();
        chk("rdata_hold", 128'(rdata0), ent(1'b1, 8'h04, 8'h22, 32'h200, t0));

        // ch0 three cycles while ch1 every cycle: one drop on each of the last two cycles.
        t0 = ts_exp;
        for (int k = 0; k < 3; k++) begin
            valid = 2'b11;
            addr  = {32'h400 + 32'(k), 32'h300 + 32'(k)};
            id    = {8'h44, 8'h33};
            len   = {8'h02, 8'h01};
            tick();
        end
        valid = 2'b00;
        tick();
        tick();
        chk("contend_num", 128'(num0), 128'd6);
        chk("contend_drop", 128'(drop0), 128'd2);
        rd(4'd2, d0, d1);
        chk("contend_e2", 128'(d0), ent(1'b0, 8'h01, 8'h33, 32'h300, t0));
        rd(4'd3, d0, d1);
        chk("contend_e3", 128'(d0), ent(1'b1, 8'h02, 8'h44, 32'h400, t0));
        rd(4'd4, d0, d1);
        chk("contend_e4", 128'(d0), ent(1'b0, 8'h01, 8'h33, 32'h301, t0 + 32'd1));
        rd(4'd5, d0, d1);
        chk("contend_e5", 128'(d0), ent(1'b1, 8'h02, 8'h44, 32'h402, t0 + 32'd2));

        en = 1'b0; valid = 2'b01;
        tick();
        valid = 2'b00;
        tick();
        tick();
        chk("disabled_num", 128'(num0), 128'd6);
        en = 1'b1;

        // Clear, then re-clear mid-pass: clearing restarts from address 0.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        wait_clear("restart_clear_cycles");
        chk("clr_num", 128'(num0), 128'd0);
        chk("clr_drop", 128'(drop0), 128'd0);
        chk("clr_wrptr", 128'(ptr0), 128'd0);

        // 18 back-to-back single-channel handshakes.
        t0 = ts_exp;
        for (int k = 1; k <= 18; k++) begin
            valid = 2'b01;
            addr  = {32'h0, 32'h1000 + 32'(k)};
            id    = {8'h0, 8'(k)};
            len   = {8'h0, 8'(k)};
            tick();
            if (k == 12) begin
                chk("af_below", 128'(af0), 128'd0);
                chk("af_below_num", 128'(num0), 128'd11);
            end
            if (k == 13) begin
                chk("af_at_12", 128'(af0), 128'd1);
                chk("af_ring_zero", 128'(af1), 128'd0);
            end
            if (k == 17) begin
                chk("full_after_16", 128'(full0), 128'd1);
                chk("full_num", 128'(num0), 128'd16);
            end
        end
        valid = 2'b00;
        tick();
        chk("full_drop", 128'(drop0), 128'd1);
        chk("full_hold", 128'(full0), 128'd1);
        chk("full_wrptr", 128'(ptr0), 128'd0);
        chk("ring_wrapped", 128'(wrapped1), 128'd1);
        chk("ring_wrptr", 128'(ptr1), 128'd2);
        chk("ring_num", 128'(num1), 128'd16);
        chk("ring_full", 128'(full1), 128'd0);
        chk("ring_drop", 128'(drop1), 128'd0);
        chk("stop_wrapped", 128'(wrapped0), 128'd0);
        rd(4'd0, d0, d1);
        chk("stop_e0", 128'(d0), ent(1'b0, 8'd1, 8'd1, 32'h1001, t0));
        chk("ring_e0", 128'(d1), ent(1'b0, 8'd17, 8'd17, 32'h1011, t0 + 32'd16));
        rd(4'd1, d0, d1);
        chk("ring_e1", 128'(d1), ent(1'b0, 8'd18, 8'd18, 32'h1012, t0 + 32'd17));
        rd(4'd15, d0, d1);
        chk("stop_e15", 128'(d0), ent(1'b0, 8'd16, 8'd16, 32'h1010, t0 + 32'd15));

        valid = 2'b01;
        tick();
        valid = 2'b00;
        tick();
        chk("full_drop2", 128'(drop0), 128'd2);
        chk("full_num_hold", 128'(num0), 128'd16);

        // Clear out of FULL.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        wait_clear("full_clear_cycles");
        chk("fc_full", 128'(full0), 128'd0);
        chk("fc_af", 128'(af0), 128'd0);
        chk("fc_num", 128'(num0), 128'd0);
        chk("fc_drop", 128'(drop0), 128'd0);
        chk("fc_wrptr", 128'(ptr0), 128'd0);
        chk("fc_wrapped", 128'(wrapped1), 128'd0);
        for (int a = 0; a < 16; a++) begin
            rd(4'(a), d0, d1);
            chk("fc_mem0", 128'(d0), 128'd0);
            chk("fc_mem1", 128'(d1), 128'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
